// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: goal detection, scoring and serve/rally/point/win sequencing for pong.
// Build option PONG_WIN_BY_TWO_EN: win needs a two-point lead, with deuce collapse at WIN_SCORE.
module pong_match_ctrl #(
  parameter int BOARD_WIDTH   = 40,
  parameter int BOARD_HEIGHT  = 30,
  parameter int PADDLE_HEIGHT = 6,
  parameter int WIN_SCORE     = 9,
  parameter int SCORE_W       = 4,
  parameter int SERVE_FRAMES  = 60
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_frame_tick,
  input  logic [5:0]         i_ball_x,
  input  logic [5:0]         i_ball_y,
  input  logic [5:0]         i_paddle_y1,
  input  logic [5:0]         i_paddle_y2,
  output logic [2:0]         o_state,
  output logic [SCORE_W-1:0] o_score_p1,
  output logic [SCORE_W-1:0] o_score_p2,
  output logic               o_ball_en,
  output logic               o_ball_reset,
  output logic               o_serve_dir,
  output logic [1:0]         o_winner
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SERVE   = 3'd1;
  localparam logic [2:0] S_RUNNING = 3'd2;
  localparam logic [2:0] S_POINT   = 3'd3;
  localparam logic [2:0] S_P1_WINS = 3'd4;
  localparam logic [2:0] S_P2_WINS = 3'd5;

  // Counter only needs to reach SERVE_FRAMES-1; the final tick releases the ball.
  localparam int                 CNT_W     = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [5:0]         RIGHT_COL = 6'(BOARD_WIDTH - 1);
  localparam logic [6:0]         PAD_SPAN  = 7'(PADDLE_HEIGHT - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  generate
    if (BOARD_WIDTH < 4 || BOARD_WIDTH > 64 || BOARD_HEIGHT < 1 || BOARD_HEIGHT > 64 ||
        SERVE_FRAMES < 1 || WIN_SCORE < 1 || WIN_SCORE > (1 << SCORE_W) - 2) begin : g_bad_params
      $error("pong_match_ctrl: illegal parameter combination");
    end
  endgenerate

  logic [2:0]         state_reg, state_next;
  logic [SCORE_W-1:0] score_p1_reg, score_p1_next;
  logic [SCORE_W-1:0] score_p2_reg, score_p2_next;
  logic               serve_dir_reg, serve_dir_next;
  logic               scorer_reg, scorer_next;
  logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
  logic               entry_pend_reg, entry_pend_next;
  logic               ball_reset_reg, ball_reset_next;
  logic               ball_en_reg, ball_en_next;
  logic [1:0]         winner_reg, winner_next;

  logic               serve_entry;
  logic               p1_goal, p2_goal, win_hit;
  logic [6:0]         ball_y_w, pad1_top, pad2_top;
  logic [SCORE_W-1:0] pt_score, pt_opp;

  // Paddle spans are compared at 7 bits so a paddle at the bottom edge cannot wrap.
  assign ball_y_w = {1'b0, i_ball_y};
  assign pad1_top = {1'b0, i_paddle_y1};
  assign pad2_top = {1'b0, i_paddle_y2};
  assign p2_goal  = (i_ball_x == 6'd0) &&
                    ((ball_y_w < pad1_top) || (ball_y_w > pad1_top + PAD_SPAN));
  assign p1_goal  = (i_ball_x == RIGHT_COL) &&
                    ((ball_y_w < pad2_top) || (ball_y_w > pad2_top + PAD_SPAN));

  // scorer_reg: 0 = P1 took the last point, 1 = P2.
  assign pt_score = scorer_reg ? score_p2_reg : score_p1_reg;
  assign pt_opp   = scorer_reg ? score_p1_reg : score_p2_reg;
`ifdef PONG_WIN_BY_TWO_EN
  assign win_hit  = (pt_score >= WIN) &&
                    ({1'b0, pt_score} >= {1'b0, pt_opp} + (SCORE_W+1)'(2));
`else
  assign win_hit  = (pt_score == WIN);
`endif

  assign serve_entry = (state_next == S_SERVE) && (state_reg != S_SERVE);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_reg      <= S_IDLE;
      score_p1_reg   <= '0;
      score_p2_reg   <= '0;
      serve_dir_reg  <= 1'b0;
      scorer_reg     <= 1'b0;
      frame_cnt_reg  <= '0;
      entry_pend_reg <= 1'b0;
      ball_reset_reg <= 1'b0;
      ball_en_reg    <= 1'b0;
      winner_reg     <= 2'b00;
    end else begin
      state_reg      <= state_next;
      score_p1_reg   <= score_p1_next;
      score_p2_reg   <= score_p2_next;
      serve_dir_reg  <= serve_dir_next;
      scorer_reg     <= scorer_next;
      frame_cnt_reg  <= frame_cnt_next;
      entry_pend_reg <= entry_pend_next;
      ball_reset_reg <= ball_reset_next;
      ball_en_reg    <= ball_en_next;
      winner_reg     <= winner_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    score_p1_next  = score_p1_reg;
    score_p2_next  = score_p2_reg;
    serve_dir_next = serve_dir_reg;
    scorer_next    = scorer_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      S_IDLE, S_P1_WINS, S_P2_WINS: begin
        if (i_start) begin
          score_p1_next  = '0;
          score_p2_next  = '0;
          serve_dir_next = 1'b1;
          state_next     = S_SERVE;
        end
      end
      S_SERVE: begin
        if (i_frame_tick) begin
          if (frame_cnt_reg == CNT_LAST) state_next = S_RUNNING;
          else frame_cnt_next = frame_cnt_reg + 1'b1;
        end
      end
      S_RUNNING: begin
        if (i_frame_tick) begin
          if (p2_goal) begin
            score_p2_next  = score_p2_reg + 1'b1;
            serve_dir_next = 1'b0;
            scorer_next    = 1'b1;
            state_next     = S_POINT;
          end else if (p1_goal) begin
            score_p1_next  = score_p1_reg + 1'b1;
            serve_dir_next = 1'b1;
            scorer_next    = 1'b0;
            state_next     = S_POINT;
          end
        end
      end
      S_POINT: begin
        if (win_hit) begin
          state_next = scorer_reg ? S_P2_WINS : S_P1_WINS;
        end else begin
          state_next = S_SERVE;
`ifdef PONG_WIN_BY_TWO_EN
          // Deuce collapse keeps both scores within WIN_SCORE+1.
          if (score_p1_reg == WIN && score_p2_reg == WIN) begin
            score_p1_next = WIN - 1'b1;
            score_p2_next = WIN - 1'b1;
          end
`endif
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (serve_entry) frame_cnt_next = '0;
  end

  always_comb begin
    ball_en_next    = (state_next == S_RUNNING);
    entry_pend_next = serve_entry;
    ball_reset_next = entry_pend_reg;
    winner_next     = 2'b00;
    if (state_next == S_P1_WINS) winner_next = 2'b01;
    else if (state_next == S_P2_WINS) winner_next = 2'b10;
  end

  assign o_state      = state_reg;
  assign o_score_p1   = score_p1_reg;
  assign o_score_p2   = score_p2_reg;
  assign o_ball_en    = ball_en_reg;
  assign o_ball_reset = ball_reset_reg;
  assign o_serve_dir  = serve_dir_reg;
  assign o_winner     = winner_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with default parameters; win-by-two block under PONG_WIN_BY_TWO_EN.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       i_rst_n, i_start, i_frame_tick;
  logic [5:0] i_ball_x, i_ball_y, i_paddle_y1, i_paddle_y2;
  logic [2:0] o_state;
  logic [3:0] o_score_p1, o_score_p2;
  logic       o_ball_en, o_ball_reset, o_serve_dir;
  logic [1:0] o_winner;

  int n_checks = 0;
  int n_errors = 0;
  int s1 = 0;
  int s2 = 0;

  pong_match_ctrl dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_frame_tick (i_frame_tick),
    .i_ball_x     (i_ball_x),
    .i_ball_y     (i_ball_y),
    .i_paddle_y1  (i_paddle_y1),
    .i_paddle_y2  (i_paddle_y2),
    .o_state      (o_state),
    .o_score_p1   (o_score_p1),
    .o_score_p2   (o_score_p2),
    .o_ball_en    (o_ball_en),
    .o_ball_reset (o_ball_reset),
    .o_serve_dir  (o_serve_dir),
    .o_winner     (o_winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic cyc(input logic tick);
    i_frame_tick = tick;
    @(posedge clk);
    #1;
    i_frame_tick = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, o_state, 0);
    check({tag, "_p1"}, o_score_p1, 0);
    check({tag, "_p2"}, o_score_p2, 0);
    check({tag, "_ball_en"}, o_ball_en, 0);
    check({tag, "_ball_reset"}, o_ball_reset, 0);
    check({tag, "_serve_dir"}, o_serve_dir, 0);
    check({tag, "_winner"}, o_winner, 0);
  endtask

  // Called right after SERVE entry; 60 counted ticks release the ball.
  task automatic serve_run();
    for (int i = 0; i < 59; i++) cyc(1'b1);
    check("serve_hold", o_state, 1);
    check("serve_hold_ball_en", o_ball_en, 0);
    cyc(1'b1);
    check("serve_release", o_state, 2);
    check("serve_release_ball_en", o_ball_en, 1);
  endtask

  // From RUNNING: score a goal for P1 (p1=1) or P2, step through POINT, resume if no winner.
  task automatic goal(input bit p1);
    bit win;
    int sc, op;
    i_paddle_y1 = 6'd0;
    i_paddle_y2 = 6'd0;
    i_ball_y    = 6'd20;
    i_ball_x    = p1 ? 6'd39 : 6'd0;
    cyc(1'b1);
    if (p1) s1++; else s2++;
    check("goal_point_state", o_state, 3);
    check("goal_score_p1", o_score_p1, s1);
    check("goal_score_p2", o_score_p2, s2);
    check("goal_serve_dir", o_serve_dir, p1 ? 1 : 0);
    i_ball_x = 6'd20;
    cyc(1'b0);
    sc = p1 ? s1 : s2;
    op = p1 ? s2 : s1;
`ifdef PONG_WIN_BY_TWO_EN
    win = (sc >= 9) && (sc >= op + 2);
    if (!win && s1 == 9 && s2 == 9) begin
      s1 = 8;
      s2 = 8;
    end
`else
    win = (sc == 9);
`endif
    if (win) begin
      check("win_state", o_state, p1 ? 4 : 5);
      check("win_winner", o_winner, p1 ? 1 : 2);
      check("win_ball_en", o_ball_en, 0);
    end else begin
      check("after_point_state", o_state, 1);
      check("after_point_p1", o_score_p1, s1);
      check("after_point_p2", o_score_p2, s2);
      serve_run();
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_frame_tick = 1'b0;
    i_ball_x = 6'd20; i_ball_y = 6'd15; i_paddle_y1 = 6'd5; i_paddle_y2 = 6'd5;
    cyc(1'b0);
    cyc(1'b0);
    check_reset_values("reset");

    // Start: SERVE entry, delayed one-cycle ball_reset pulse, 60-tick serve.
    i_rst_n = 1'b1;
    i_start = 1'b1;
    cyc(1'b0);
    i_start = 1'b0;
    check("start_state", o_state, 1);
    check("start_serve_dir", o_serve_dir, 1);
    check("start_ball_reset_entry", o_ball_reset, 0);
    cyc(1'b0);
    check("start_ball_reset_pulse", o_ball_reset, 1);
    cyc(1'b0);
    check("start_ball_reset_drop", o_ball_reset, 0);
    serve_run();

    // P1 paddle spans rows 5..10.
    i_paddle_y1 = 6'd5; i_ball_x = 6'd0; i_ball_y = 6'd8;
    cyc(1'b1);
    check("p1_block_state", o_state, 2);
    check("p1_block_score", o_score_p2, 0);
    i_ball_y = 6'd10;
    cyc(1'b1);
    check("p1_block_edge_state", o_state, 2);
    i_ball_y = 6'd20;
    cyc(1'b0);
    check("no_tick_no_goal", o_state, 2);
    cyc(1'b1);
    s2 = 1;
    check("p2_goal_state", o_state, 3);
    check("p2_goal_score", o_score_p2, 1);
    check("p2_goal_dir", o_serve_dir, 0);
    check("p2_goal_ball_en", o_ball_en, 0);
    i_ball_x = 6'd20;
    cyc(1'b1);
    check("point_one_cycle", o_state, 1);
    check("point_tick_ignored", o_score_p2, 1);
    cyc(1'b0);
    check("serve_ball_reset", o_ball_reset, 1);
    serve_run();

    // P2 paddle at bottom edge covers 27..32 without wrapping.
    i_paddle_y2 = 6'd27; i_ball_x = 6'd39; i_ball_y = 6'd29;
    cyc(1'b1);
    check("p2_bottom_no_goal", o_state, 2);
    check("p2_bottom_score", o_score_p1, 0);
    i_ball_y = 6'd26;
    cyc(1'b1);
    s1 = 1;
    check("p1_goal_state", o_state, 3);
    check("p1_goal_score", o_score_p1, 1);
    check("p1_goal_dir", o_serve_dir, 1);
    i_ball_x = 6'd20;
    cyc(1'b0);
    check("p1_goal_serve", o_state, 1);
    serve_run();

    while (s1 < 9) goal(1'b1);

    // Winner holds; ticks at a goal position change nothing.
    i_ball_x = 6'd39; i_paddle_y2 = 6'd0; i_ball_y = 6'd20;
    cyc(1'b1);
    check("win_hold_state", o_state, 4);
    check("win_hold_p1", o_score_p1, 9);
    check("win_hold_p2", o_score_p2, 1);
    check("win_hold_winner", o_winner, 1);
    i_ball_x = 6'd20;
    i_start = 1'b1;
    cyc(1'b0);
    i_start = 1'b0;
    s1 = 0; s2 = 0;
    check("restart_state", o_state, 1);
    check("restart_p1", o_score_p1, 0);
    check("restart_p2", o_score_p2, 0);
    check("restart_winner", o_winner, 0);
    check("restart_dir", o_serve_dir, 1);
    cyc(1'b0);
    serve_run();

`ifdef PONG_WIN_BY_TWO_EN
    for (int i = 0; i < 8; i++) begin
      goal(1'b1);
      goal(1'b0);
    end
    goal(1'b1);
    goal(1'b0);
    check("deuce_p1", o_score_p1, 8);
    check("deuce_p2", o_score_p2, 8);
    goal(1'b1);
    check("adv_p1", o_score_p1, 9);
    goal(1'b1);
    check("w2_p1", o_score_p1, 10);
    check("w2_state", o_state, 4);
    i_start = 1'b1;
    cyc(1'b0);
    i_start = 1'b0;
    s1 = 0; s2 = 0;
    cyc(1'b0);
    serve_run();
`endif

    // Mid-rally reset at 3/5.
    for (int i = 0; i < 8; i++) goal(i < 3);
    check("pre_reset_p1", o_score_p1, 3);
    check("pre_reset_p2", o_score_p2, 5);
    check("pre_reset_state", o_state, 2);
    i_rst_n = 1'b0;
    cyc(1'b0);
    i_rst_n = 1'b1;
    check_reset_values("mid_reset");
    cyc(1'b0);
    check("post_reset_state", o_state, 0);

    // Reset right after SERVE entry must cancel the pending ball_reset.
    i_start = 1'b1;
    cyc(1'b0);
    i_start = 1'b0;
    i_rst_n = 1'b0;
    cyc(1'b0);
    i_rst_n = 1'b1;
    cyc(1'b0);
    check("no_residual_pulse", o_ball_reset, 0);
    check("no_residual_state", o_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Parametrised match controller for the pong design. It sits between the paddle/ball logic and the VGA draw path, working in board-tile coordinates. It detects goals from ball and paddle positions, keeps both players' scores, and sequences serve, rally, point and win. It gates ball motion and tells the draw logic which match phase to render.

## Interface
Parameters:
- BOARD_WIDTH, 40, board width in tiles; must be >= 4
- BOARD_HEIGHT, 30, board height in tiles
- PADDLE_HEIGHT, 6, paddle height in tiles
- WIN_SCORE, 9, points needed to win; range 1 to 2^SCORE_W-2
- SCORE_W, 4, score counter width
- SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released; must be >= 1

Ports:
- clk  in  1  system clock; the only clock
- i_rst_n  in  1  reset; synchronous, active-low
- i_start  in  1  start/restart request, level-sampled
- i_frame_tick  in  1  single-cycle pulse, once per frame
- i_ball_x  in  6  ball column, in tiles
- i_ball_y  in  6  ball row, in tiles
- i_paddle_y1  in  6  top row of P1 paddle, column 0
- i_paddle_y2  in  6  top row of P2 paddle, column BOARD_WIDTH-1
- o_state  out  3  current state encoding
- o_score_p1  out  SCORE_W  P1 score
- o_score_p2  out  SCORE_W  P2 score
- o_ball_en  out  1  ball may move; high only in RUNNING
- o_ball_reset  out  1  one-cycle pulse; recentre the ball
- o_serve_dir  out  1  serve direction: 0 = toward P1, 1 = toward P2
- o_winner  out  2  00 none, 01 P1, 10 P2

## Operation
State encodings:
- IDLE = 0
- SERVE = 1
- RUNNING = 2
- POINT = 3
- P1_WINS = 4
- P2_WINS = 5
- Encodings 6 and 7 are unused and go to IDLE on the next cycle.

Transitions:
- IDLE, with i_start = 1:
  - Clear both scores.
  - Set o_serve_dir = 1.
  - Go to SERVE.
- SERVE entry: pulse o_ball_reset for exactly one cycle and clear the frame counter.
- SERVE: count i_frame_tick pulses. On the tick that brings the count to SERVE_FRAMES, go to RUNNING.
- RUNNING: evaluate goals only on cycles where i_frame_tick = 1.
  - P2 scores when i_ball_x == 0 and i_ball_y is outside [i_paddle_y1, i_paddle_y1+PADDLE_HEIGHT-1].
  - P1 scores when i_ball_x == BOARD_WIDTH-1 and i_ball_y is outside [i_paddle_y2, i_paddle_y2+PADDLE_HEIGHT-1].
  - Paddle range arithmetic is 7 bits wide, so there is no wrap when a paddle sits at the bottom edge.
  - On a goal: increment the scorer's score, set o_serve_dir toward the player who conceded, and go to POINT.
- POINT, one cycle only:
  - If the scorer meets the win rule, go to P1_WINS or P2_WINS.
  - Otherwise go to SERVE.
- Win rule (base build): score == WIN_SCORE.
- P1_WINS / P2_WINS:
  - o_winner = 01 / 10; scores frozen.
  - i_start = 1 clears scores and o_winner and goes to SERVE with o_serve_dir = 1.
- i_start is ignored in SERVE, RUNNING and POINT.

## Timing
- Reset values, all registered and applied on the clk edge while i_rst_n = 0:
  - o_state = IDLE
  - both scores = 0
  - o_ball_en = 0, o_ball_reset = 0
  - o_serve_dir = 0
  - o_winner = 00
  - frame counter = 0
- Reset asserted mid-match: all of the above on the next edge, with no residual ball_reset pulse.
- Goal latency:
  - Tick at edge N: score and state = POINT visible after N.
  - SERVE or WIN visible after edge N+1.
  - o_ball_reset high for the cycle after N+2 on the SERVE path.
- o_ball_en falls on the same edge that leaves RUNNING.
- An i_frame_tick that arrives while in POINT is ignored.
- The SERVE count starts with the first tick after entry.
- If a tick coincides with the SERVE entry edge, it is not counted.

## Configuration
- PONG_WIN_BY_TWO_EN defined:
  - Win rule becomes: scorer >= WIN_SCORE and scorer - opponent >= 2.
  - If the scores are equal at WIN_SCORE after a point, both are set to WIN_SCORE-1 in POINT. This is the deuce collapse, so neither score exceeds WIN_SCORE+1.
- PONG_WIN_BY_TWO_EN undefined: win at WIN_SCORE exactly, with no deuce logic.

## Test plan
- Reset, then i_start. After SERVE_FRAMES=60 ticks, o_state = 2 and o_ball_en = 1. o_ball_reset pulsed once, the cycle after SERVE entry.
- RUNNING, i_ball_x=0, i_ball_y=20, i_paddle_y1=5, tick:
  - o_score_p2 = 1, o_serve_dir = 0
  - POINT for one cycle, then SERVE
  - with i_ball_y=8, no score
- P1 scores 9 goals with WIN_SCORE=9: o_state = 4, o_winner = 01. A further tick changes nothing; i_start gives scores 0 and SERVE.
- Reset pulsed for one cycle mid-RUNNING with scores 3/5: next cycle, all outputs at reset values.
- PONG_WIN_BY_TWO_EN, at 8/8 then P1 and P2 each score:
  - after both points, scores are 8/8 (collapsed from 9/9)
  - P1 then scores twice: 9/8, then 10/8, then P1_WINS
- i_paddle_y2=27 (range 27..32), ball at x=39, y=29: no goal.
